// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Turns mnemonic-level instruction requests into 32-bit MIPS words and
//   streams them into instruction memory at consecutive word addresses.
//   A small FIFO between the encoder and the IM write port absorbs IM
//   backpressure, so the request side only stalls when the FIFO is full.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, base_addr_i  begin a load at base_addr_i (only honoured when idle)
//   in_valid_i/in_ready_o request handshake; in_last_i marks the final request
//   in_mnem_i             instruction class (0..20 legal, 21..31 illegal)
//   in_rs_i/in_rt_i/in_rd_i/in_shamt_i/in_imm_i/in_target_i  raw fields
//   im_we_o/im_ready_i    IM write handshake
//   im_addr_o, im_wdata_o IM word address and encoded word of the current write
//   busy_o, done_o        load in progress / one-cycle completion pulse
//   err_o                 sticky flag: an illegal request was dropped
//   words_written_o       completed IM transfers since the last start
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_last_i,
  input  logic [4:0]        in_mnem_i,
  input  logic [4:0]        in_rs_i,
  input  logic [4:0]        in_rt_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_shamt_i,
  input  logic [15:0]       in_imm_i,
  input  logic [25:0]       in_target_i,
  output logic              im_we_o,
  input  logic              im_ready_i,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_written_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-1:0] imAddr_q;
  logic [ADDR_W:0]   wordsWritten_q;
  logic [31:0]       fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q;
  logic [PTR_W-1:0]  rdPtr_q;
  logic [PTR_W:0]    count_q;

  logic        fifoFull;
  logic        fifoEmpty;
  logic        accept;
  logic        push;
  logic        pop;
  logic        encLegal;
  logic [31:0] encWord;

  // Full is judged on stored occupancy only; a same-cycle pop does not
  // open a slot for the requester.
  assign fifoFull  = (count_q == DEPTH_L);
  assign fifoEmpty = (count_q == '0);
  assign accept    = in_valid_i && in_ready_o;
  assign push      = accept && encLegal;
  assign pop       = im_we_o && im_ready_i;

  assign in_ready_o      = (state_q == RUN) && !fifoFull;
  assign im_we_o         = !fifoEmpty;
  assign im_addr_o       = imAddr_q;
  assign im_wdata_o      = fifoEmpty ? 32'd0 : fifoMem_q[rdPtr_q];
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign words_written_o = wordsWritten_q;

  // Combinational encoder. Fields that a class does not use are forced to
  // zero so the word matches what the control decoder expects.
  always_comb begin
    encWord  = 32'd0;
    encLegal = 1'b1;
    case (in_mnem_i)
      5'd0:  encWord = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'd0, 6'b100001};
      5'd1:  encWord = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'd0, 6'b100011};
      5'd2:  encWord = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'd0, 6'b100000};
      5'd3:  encWord = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'd0, 6'b100010};
      5'd4:  encWord = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'd0, 6'b100100};
      5'd5:  encWord = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'd0, 6'b100101};
      5'd6:  encWord = {6'b000000, 5'd0, in_rt_i, in_rd_i, in_shamt_i, 6'b000000};
      5'd7:  encWord = {6'b000000, 5'd0, in_rt_i, in_rd_i, in_shamt_i, 6'b000010};
      5'd8:  encWord = {6'b000000, 5'd0, in_rt_i, in_rd_i, in_shamt_i, 6'b000011};
      5'd9:  encWord = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'd0, 6'b101010};
      5'd10: encWord = {6'b000000, in_rs_i, 15'd0, 6'b001000};
      5'd11: encWord = {6'b001000, in_rs_i, in_rt_i, in_imm_i};
      5'd12: encWord = {6'b001101, in_rs_i, in_rt_i, in_imm_i};
      5'd13: encWord = {6'b001010, in_rs_i, in_rt_i, in_imm_i};
      5'd14: encWord = {6'b000100, in_rs_i, in_rt_i, in_imm_i};
      5'd15: encWord = {6'b000101, in_rs_i, in_rt_i, in_imm_i};
      5'd16: encWord = {6'b100011, in_rs_i, in_rt_i, in_imm_i};
      5'd17: encWord = {6'b101011, in_rs_i, in_rt_i, in_imm_i};
      5'd18: encWord = {6'b001111, 5'd0, in_rt_i, in_imm_i};
      5'd19: encWord = {6'b000010, in_target_i};
      5'd20: encWord = {6'b000011, in_target_i};
      default: encLegal = 1'b0;
    endcase
  end

  // Control FSM, FIFO and IM address/count registers. The FIFO storage is
  // not reset; only the pointers and occupancy are, which flushes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      imAddr_q       <= '0;
      wordsWritten_q <= '0;
      wrPtr_q        <= '0;
      rdPtr_q        <= '0;
      count_q        <= '0;
    end else begin
      if (pop) begin
        rdPtr_q        <= rdPtr_q + PTR_W'(1);
        imAddr_q       <= imAddr_q + ADDR_W'(1);
        wordsWritten_q <= wordsWritten_q + (ADDR_W+1)'(1);
      end
      if (push) begin
        fifoMem_q[wrPtr_q] <= encWord;
        wrPtr_q            <= wrPtr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PTR_W+1)'(1);
      end
      // An illegal request still completes its handshake but is dropped.
      if (accept && !encLegal) begin
        err_q <= 1'b1;
      end

      // The FIFO is always empty in IDLE, so the start assignments below
      // never compete with a pop.
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q        <= RUN;
            busy_q         <= 1'b1;
            imAddr_q       <= base_addr_i;
            err_q          <= 1'b0;
            wordsWritten_q <= '0;
          end
        end
        RUN: begin
          if (accept && in_last_i) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifoEmpty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed request streams, a queue-based
// reference model of the whole load, and literal spot checks.
module tb_instr_encoder;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] baseAddr;
  logic              inValid;
  logic              inReady;
  logic              inLast;
  logic [4:0]        inMnem, inRs, inRt, inRd, inShamt;
  logic [15:0]       inImm;
  logic [25:0]       inTarget;
  logic              imWe;
  logic              imReady;
  logic [ADDR_W-1:0] imAddr;
  logic [31:0]       imWdata;
  logic              busy, done, err;
  logic [ADDR_W:0]   wordsWritten;

  int vectorsApplied = 0;
  int miscompares    = 0;

  // Reference model state: phase 0 idle, 1 accepting, 2 draining, 3 done.
  int                mPhase = 0;
  logic [31:0]       mQueue[$];
  logic [ADDR_W-1:0] mAddr  = '0;
  logic              mErr   = 1'b0;
  logic [ADDR_W:0]   mCount = '0;

  // Every IM transfer seen, for literal checks per test.
  logic [ADDR_W-1:0] logAddr[$];
  logic [31:0]       logData[$];

  logic [5:0] functTab [11] = '{6'h21, 6'h23, 6'h20, 6'h22, 6'h24, 6'h25,
                                6'h00, 6'h02, 6'h03, 6'h2A, 6'h08};
  logic [5:0] opTab [8]     = '{6'h08, 6'h0D, 6'h0A, 6'h04, 6'h05, 6'h23,
                                6'h2B, 6'h0F};

  instr_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(baseAddr),
    .in_valid_i(inValid), .in_ready_o(inReady), .in_last_i(inLast),
    .in_mnem_i(inMnem), .in_rs_i(inRs), .in_rt_i(inRt), .in_rd_i(inRd),
    .in_shamt_i(inShamt), .in_imm_i(inImm), .in_target_i(inTarget),
    .im_we_o(imWe), .im_ready_i(imReady), .im_addr_o(imAddr),
    .im_wdata_o(imWdata), .busy_o(busy), .done_o(done), .err_o(err),
    .words_written_o(wordsWritten)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Encoding built from field positions with arithmetic shifts.
  function automatic logic [31:0] modelEncode(input int m, input logic [4:0] rs, rt, rd, sh,
                                              input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] w;
    logic [4:0]  ers, ert, erd, esh;
    bit          isShift;
    w = 32'd0;
    if (m <= 10) begin
      isShift = (m >= 6) && (m <= 8);
      ers = isShift ? 5'd0 : rs;
      esh = isShift ? sh : 5'd0;
      ert = (m == 10) ? 5'd0 : rt;
      erd = (m == 10) ? 5'd0 : rd;
      w = (32'(ers) << 21) | (32'(ert) << 16) | (32'(erd) << 11) | (32'(esh) << 6) | 32'(functTab[m]);
    end else if (m <= 18) begin
      ers = (m == 18) ? 5'd0 : rs;
      w = (32'(opTab[m-11]) << 26) | (32'(ers) << 21) | (32'(rt) << 16) | 32'(imm);
    end else if (m <= 20) begin
      w = (32'((m == 19) ? 6'd2 : 6'd3) << 26) | 32'(tgt);
    end
    return w;
  endfunction

  // Compare every output against the model each cycle, then advance the
  // model by what the coming rising edge will do with the current inputs.
  always @(negedge clk) begin
    logic        expReady, expWe, accept, pop;
    logic [31:0] expData;
    int          nextPhase;
    expReady = (mPhase == 1) && (mQueue.size() < DEPTH);
    expWe    = (mQueue.size() != 0);
    expData  = expWe ? mQueue[0] : 32'd0;
    checkOutput("in_ready", inReady, expReady);
    checkOutput("im_we", imWe, expWe);
    checkOutput("im_addr", imAddr, mAddr);
    checkOutput("im_wdata", imWdata, expData);
    checkOutput("busy", busy, mPhase != 0);
    checkOutput("done", done, mPhase == 3);
    checkOutput("err", err, mErr);
    checkOutput("words_written", wordsWritten, mCount);

    if (!rst && imWe && imReady) begin
      logAddr.push_back(imAddr);
      logData.push_back(imWdata);
    end

    if (rst) begin
      mPhase = 0;
      mQueue.delete();
      mAddr  = '0;
      mErr   = 1'b0;
      mCount = '0;
    end else begin
      accept    = inValid && expReady;
      pop       = expWe && imReady;
      nextPhase = mPhase;
      case (mPhase)
        0: if (start) begin
             nextPhase = 1;
             mAddr     = baseAddr;
             mErr      = 1'b0;
             mCount    = '0;
           end
        1: if (accept && inLast) nextPhase = 2;
        2: if (mQueue.size() == 0) nextPhase = 3;
        default: nextPhase = 0;
      endcase
      if (pop) begin
        void'(mQueue.pop_front());
        mAddr  = mAddr + ADDR_W'(1);
        mCount = mCount + (ADDR_W+1)'(1);
      end
      if (accept) begin
        if (inMnem <= 5'd20)
          mQueue.push_back(modelEncode(int'(inMnem), inRs, inRt, inRd, inShamt, inImm, inTarget));
        else
          mErr = 1'b1;
      end
      mPhase = nextPhase;
    end
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic startLoad(input logic [ADDR_W-1:0] base);
    start    = 1'b1;
    baseAddr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [4:0] m, rs, rt, rd, sh,
                               input logic [15:0] imm, input logic [25:0] tgt,
                               input logic last);
    int waitCycles = 0;
    inValid = 1'b1; inLast = last; inMnem = m; inRs = rs; inRt = rt;
    inRd = rd; inShamt = sh; inImm = imm; inTarget = tgt;
    forever begin
      @(negedge clk);
      if (inReady) break;
      waitCycles++;
      if (waitCycles > 200) begin
        vectorsApplied++;
        miscompares++;
        $display("[TB] FAIL accept_timeout: in_ready stayed 0 for mnem %0d", m);
        break;
      end
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic waitDone();
    int waitCycles = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      waitCycles++;
      if (waitCycles > 300) begin
        vectorsApplied++;
        miscompares++;
        $display("[TB] FAIL done_timeout: done not seen, got 0, expected 1");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; baseAddr = '0; inValid = 1'b0; inLast = 1'b0;
    inMnem = '0; inRs = '0; inRt = '0; inRd = '0; inShamt = '0; inImm = '0;
    inTarget = '0; imReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Pin the model to hand-encoded words.
    checkOutput("enc_addu", modelEncode(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0), 32'h00221821);
    checkOutput("enc_ori", modelEncode(12, 5'd0, 5'd5, 5'd0, 5'd0, 16'h1234, 26'h0), 32'h34051234);
    checkOutput("enc_beq", modelEncode(14, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0), 32'h1022FFFF);
    checkOutput("enc_jal", modelEncode(20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100), 32'h0C000100);
    checkOutput("enc_sll", modelEncode(6, 5'd7, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0), 32'h000220C0);
    checkOutput("enc_lw", modelEncode(16, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0), 32'h8FA80004);

    // Single ADDU load.
    clearLog();
    startLoad(10'h010);
    applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    waitDone();
    checkOutput("t1_count", logAddr.size(), 1);
    checkOutput("t1_addr", logAddr[0], 10'h010);
    checkOutput("t1_data", logData[0], 32'h00221821);

    // ORI/BEQ/JAL, with a start pulse while busy that must be ignored.
    clearLog();
    startLoad(10'h100);
    applyStimulus(5'd12, 5'd0, 5'd5, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);
    startLoad(10'h200);
    applyStimulus(5'd14, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    applyStimulus(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100, 1'b1);
    waitDone();
    checkOutput("t2_count", logAddr.size(), 3);
    checkOutput("t2_addr2", logAddr[2], 10'h102);
    checkOutput("t2_data0", logData[0], 32'h34051234);
    checkOutput("t2_data1", logData[1], 32'h1022FFFF);
    checkOutput("t2_data2", logData[2], 32'h0C000100);

    // SLL (rs forced 0) and LW.
    clearLog();
    startLoad(10'h000);
    applyStimulus(5'd6, 5'd7, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0, 1'b0);
    applyStimulus(5'd16, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1);
    waitDone();
    checkOutput("t3_data0", logData[0], 32'h000220C0);
    checkOutput("t3_data1", logData[1], 32'h8FA80004);

    // IM stalled while six requests arrive; the FIFO fills at four.
    clearLog();
    imReady = 1'b0;
    startLoad(10'h020);
    fork
      begin
        for (int i = 0; i < 6; i++)
          applyStimulus(5'd11, 5'd1, 5'd2, 5'd0, 5'd0, 16'(i + 1), 26'h0, i == 5);
      end
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkOutput("t4_stall_ready", inReady, 1'b0);
        checkOutput("t4_stall_we", imWe, 1'b1);
        @(posedge clk); #1;
        imReady = 1'b1;
      end
    join
    waitDone();
    checkOutput("t4_count", logAddr.size(), 6);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t4_addr", logAddr[i], 10'h020 + 10'(i));
      checkOutput("t4_data", logData[i], 32'h20220000 + 32'(i + 1));
    end

    // Address wrap at the top of IM.
    clearLog();
    startLoad(10'h3FF);
    applyStimulus(5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3, 1'b0);
    applyStimulus(5'd18, 5'd9, 5'd4, 5'd0, 5'd0, 16'hBEEF, 26'h0, 1'b1);
    waitDone();
    checkOutput("t5_addr0", logAddr[0], 10'h3FF);
    checkOutput("t5_addr1", logAddr[1], 10'h000);
    checkOutput("t5_data1", logData[1], 32'h3C04BEEF);
    checkOutput("t5_words", wordsWritten, 11'd2);

    // Illegal mnemonic mid-stream.
    clearLog();
    startLoad(10'h040);
    applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    applyStimulus(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0);
    applyStimulus(5'd12, 5'd0, 5'd5, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1);
    waitDone();
    checkOutput("t6_err", err, 1'b1);
    checkOutput("t6_count", logAddr.size(), 2);
    checkOutput("t6_addr1", logAddr[1], 10'h041);

    // Sweep every legal mnemonic with non-zero don't-care fields.
    startLoad(10'h080);
    for (int m = 0; m <= 20; m++)
      applyStimulus(5'(m), 5'(m + 1), 5'(m + 2), 5'(m + 3), 5'(m + 4),
                    16'(m * 257), 26'(m * 12345), m == 20);
    waitDone();

    // Illegal request carrying last still completes the load.
    clearLog();
    startLoad(10'h0C0);
    applyStimulus(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
    waitDone();
    checkOutput("t6b_count", logAddr.size(), 0);
    checkOutput("t6b_err", err, 1'b1);

    // Reset in the middle of a stalled load.
    imReady = 1'b0;
    startLoad(10'h050);
    applyStimulus(5'd1, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0, 26'h0, 1'b0);
    applyStimulus(5'd2, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0, 26'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6c_we", imWe, 1'b0);
    checkOutput("t6c_busy", busy, 1'b0);
    rst = 1'b0;
    imReady = 1'b1;
    clearLog();
    startLoad(10'h060);
    applyStimulus(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    waitDone();
    checkOutput("t6c_count", logAddr.size(), 1);
    checkOutput("t6c_data", logData[0], 32'h00221825);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
